// File: rtl/cpu_pkg.sv
// Shared RV32 encoding constants, format classification and the encoder request bundle.
// Used by both the instruction encoder and the decoder.
package cpu_pkg;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_J     = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_SYS   = 7'h73;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } inst_req_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                          f = FMT_R;
      OP_I, OP_L, OP_JALR, OP_SYS:   f = FMT_I;
      OP_S:                          f = FMT_S;
      OP_B:                          f = FMT_B;
      OP_LUI, OP_AUIPC:              f = FMT_U;
      OP_J:                          f = FMT_J;
      default:                       f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational field packing for RV32 base formats; bad opcodes become NOP with err.
// Define INST_ENCODER_RANGE_CHECK_EN to also reject immediates that do not fit the format.
module inst_pack
  import cpu_pkg::*;
(
  input  inst_req_t   req,
  output logic [31:0] inst,
  output logic        err
);

  fmt_e        fmt;
  logic [31:0] enc;
  logic        range_bad;

  assign fmt = opcode_fmt(req.opcode);

  always_comb begin
    enc = '0;
    case (fmt)
      FMT_R: enc = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_I: enc = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      FMT_S: enc = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
      FMT_B: enc = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                    req.imm[4:1], req.imm[11], req.opcode};
      FMT_U: enc = {req.imm[31:12], req.rd, req.opcode};
      FMT_J: enc = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                    req.rd, req.opcode};
      default: enc = '0;
    endcase
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  // Upper bits must be a pure sign extension of the encodable field.
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = !((&req.imm[31:11]) | ~(|req.imm[31:11]));
      FMT_B:        range_bad = !((&req.imm[31:12]) | ~(|req.imm[31:12])) | req.imm[0];
      FMT_J:        range_bad = !((&req.imm[31:20]) | ~(|req.imm[31:20])) | req.imm[0];
      FMT_U:        range_bad = |req.imm[11:0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  logic imm0_unused;
  assign imm0_unused = req.imm[0];
  assign range_bad   = 1'b0;
`endif

  assign err  = (fmt == FMT_BAD) | range_bad;
  assign inst = err ? NOP : enc;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: one-deep valid/ready output register around inst_pack plus a
// delivered-instruction counter. Range checking is enabled by INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             err,
  output logic [CNT_W-1:0] inst_count
);

  inst_req_t   req;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic        accept;
  logic        deliver;

  assign req = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                 funct3: funct3, funct7: funct7, imm: imm};

  inst_pack u_pack (
    .req  (req),
    .inst (pack_inst),
    .err  (pack_err)
  );

  // Gated by rst so nothing is accepted while reset is held.
  assign in_ready = rst & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      inst       <= '0;
      err        <= 1'b0;
      inst_count <= '0;
    end else begin
      if (deliver) inst_count <= inst_count + 1'b1;
      if (accept) begin
        out_valid <= 1'b1;
        inst      <= pack_inst;
        err       <= pack_err;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a per-cycle behavioural reference model.
module tb_inst_encoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      inst;
  logic             err;
  logic [CNT_W-1:0] inst_count;

  int n_pass = 0;
  int n_tot  = 0;
  bit mdl_en = 1'b0;

  always #5 clk = ~clk;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .err(err),
    .inst_count(inst_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference encoding from the ISA field rules, using arithmetic on the immediate value.
  function automatic void model(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] im, output logic [31:0] i, output bit e);
    int   si;
    bit   ok;
    logic [31:0] rdf, r1f, r2f, f3f;
    si  = $signed(im);
    ok  = 1'b1;
    e   = 1'b0;
    rdf = 32'(d) << 7;
    r1f = 32'(s1) << 15;
    r2f = 32'(s2) << 20;
    f3f = 32'(f3) << 12;
    case (op)
      7'h33: i = (32'(f7) << 25) | r2f | r1f | f3f | rdf | 32'(op);
      7'h13, 7'h03, 7'h67, 7'h73: begin
        i  = ((im & 32'hFFF) << 20) | r1f | f3f | rdf | 32'(op);
        ok = (si >= -2048) && (si <= 2047);
      end
      7'h23: begin
        i  = (((im >> 5) & 32'h7F) << 25) | r2f | r1f | f3f | ((im & 32'h1F) << 7) | 32'(op);
        ok = (si >= -2048) && (si <= 2047);
      end
      7'h63: begin
        i  = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2f | r1f | f3f |
             (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(op);
        ok = (si >= -4096) && (si <= 4095) && ((im & 32'h1) == 0);
      end
      7'h6F: begin
        i  = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
             (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | rdf | 32'(op);
        ok = (si >= -1048576) && (si <= 1048575) && ((im & 32'h1) == 0);
      end
      7'h37, 7'h17: begin
        i  = (im & 32'hFFFF_F000) | rdf | 32'(op);
        ok = (im & 32'hFFF) == 0;
      end
      default: begin
        i = 32'h13;
        e = 1'b1;
      end
    endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
    if (!ok) begin
      i = 32'h13;
      e = 1'b1;
    end
`else
    ok = 1'b1;
`endif
  endfunction

  // Reference model: at most one bundle in flight; checked every cycle between edges.
  logic [31:0] exp_q[$];
  bit          err_q[$];
  int          m_cnt = 0;

  always @(negedge clk) begin
    bit          exp_rdy;
    logic [31:0] mi;
    bit          me;
    if (mdl_en) begin
      exp_rdy = rst && (exp_q.size() == 0 || out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("inst_count", 32'(inst_count), 32'(m_cnt));
      if (exp_q.size() != 0) begin
        chk("inst", inst, exp_q[0]);
        chk("err", 32'(err), 32'(err_q[0]));
      end
      if (!rst) begin
        exp_q.delete();
        err_q.delete();
        m_cnt = 0;
      end else begin
        if (exp_q.size() != 0 && out_ready) begin
          void'(exp_q.pop_front());
          void'(err_q.pop_front());
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        if (in_valid && exp_rdy) begin
          model(opcode, rd, rs1, rs2, funct3, funct7, imm, mi, me);
          exp_q.push_back(mi);
          err_q.push_back(me);
        end
      end
    end
  end

  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  // Sends one bundle with out_ready high and checks the registered result one cycle later.
  task automatic send_chk(input string nm, input logic [6:0] op, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] im,
                          input logic [31:0] exp, input bit exp_err);
    int          n;
    logic [31:0] mi;
    bit          me;
    model(op, d, s1, s2, f3, f7, im, mi, me);
    chk({nm, "_model"}, mi, exp);
    chk({nm, "_model_err"}, 32'(me), 32'(exp_err));
    drive(op, d, s1, s2, f3, f7, im);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk(nm, inst, exp);
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int hs;
    int n;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    idle(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(inst_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    mdl_en = 1'b1;
    rst = 1'b1;
    idle(1);

    // Stall: A held while B waits.
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    idle(1);
    drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("stall_inst", inst, 32'h0050_0093);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_count", 32'(inst_count), 32'd0);
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    chk("stall_count_after", 32'(inst_count), 32'd1);
    chk("stall_b_inst", inst, 32'h4020_81B3);
    idle(2);

    send_chk("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    send_chk("sw", 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -32'sd4, 32'hFE20_AE23, 1'b0);
    send_chk("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send_chk("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send_chk("beq", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h0020_8463, 1'b0);
    send_chk("sub", 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0);
    send_chk("bad_op", 7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    send_chk("imm2048", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
    send_chk("b_odd", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 1'b1);
    send_chk("lui_low", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
`else
    send_chk("imm2048", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0013, 1'b0);
    send_chk("b_odd", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b0);
    send_chk("lui_low", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b0);
`endif
    send_chk("imm_neg2048", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
    idle(2);

    // Reset while a bundle is held and another is offered.
    out_ready = 1'b0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    idle(1);
    chk("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    idle(1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(inst_count), 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle(1);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end

    // Back-to-back deliveries wrap the counter.
    drive(7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    hs = 0;
    n  = 0;
    while (hs < (1 << CNT_W) && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) begin
        if (hs == (1 << CNT_W) - 1) chk("wrap_pre", 32'(inst_count), 32'((1 << CNT_W) - 1));
        hs++;
      end
    end
    if (n >= 100) chk("wrap_timeout", 32'(hs), 32'(1 << CNT_W));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("wrap_count", 32'(inst_count), 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
